// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        WB_NORM = 1'b0,
        WB_REQ  = 1'b1
    } wbState_e;

    // One-hot mask selecting a single register.
    function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard of registers awaiting long-latency results, with hazard queries.
// WB_PROTO_CHECK_EN: also exposes the raw busy vector for protocol checking.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  SetEn,
    input  logic [REG_ADDR_W-1:0] SetRW,
    input  logic                  ClrEn,
    input  logic [REG_ADDR_W-1:0] ClrRW,
    input  logic [REG_ADDR_W-1:0] QA,
    input  logic [REG_ADDR_W-1:0] QB,
    output logic                  HazA,
    output logic                  HazB
`ifdef WB_PROTO_CHECK_EN
    ,
    output logic [NUM_REGS-1:0]   Busy
`endif
);

    logic [NUM_REGS-1:0] busyQ;
    logic [NUM_REGS-1:0] busyD;
    logic [NUM_REGS-1:0] setMask;
    logic [NUM_REGS-1:0] clrMask;

    // Next busy vector: a reservation wins over a same-cycle clear; $0 is never tracked.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (SetEn && (SetRW != '0)) begin
            setMask = regMask(SetRW);
        end
        if (ClrEn) begin
            clrMask = regMask(ClrRW);
        end
        busyD = (busyQ & ~clrMask) | setMask;
    end

    // Busy vector register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busyQ <= '0;
        end else begin
            busyQ <= busyD;
        end
    end

    assign HazA = busyQ[QA];
    assign HazB = busyQ[QB];

`ifdef WB_PROTO_CHECK_EN
    assign Busy = busyQ;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port, sharing it between the pipeline writeback (P, no
// backpressure) and the long-latency unit (L, valid/ready). L is forced through by
// stalling the pipeline after STARVE_LIMIT consecutive waiting cycles.
// WB_PROTO_CHECK_EN: adds the sticky ProtoErr output and its checks.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned STARVE_W     = 3
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  PWr,
    input  logic [REG_ADDR_W-1:0] PRW,
    input  logic [DATA_W-1:0]     PBus,
    input  logic                  LValid,
    output logic                  LReady,
    input  logic [REG_ADDR_W-1:0] LRW,
    input  logic [DATA_W-1:0]     LBus,
    input  logic                  ResvEn,
    input  logic [REG_ADDR_W-1:0] ResvRW,
    input  logic [REG_ADDR_W-1:0] QA,
    input  logic [REG_ADDR_W-1:0] QB,
    output logic                  HazA,
    output logic                  HazB,
    output logic                  StallPipe,
    output logic [REG_ADDR_W-1:0] RW,
    output logic [DATA_W-1:0]     BusW,
    output logic                  RegWr
`ifdef WB_PROTO_CHECK_EN
    ,
    output logic                  ProtoErr
`endif
);

    localparam logic [STARVE_W-1:0] LimitVal = STARVE_W'(STARVE_LIMIT);

    wbState_e            state;
    logic [STARVE_W-1:0] starveCnt;
    logic [STARVE_W-1:0] cntNext;
    logic                lHs;
    logic                pAcc;
    logic                forceNow;

    // In REQ the slot belongs to L; otherwise P has priority.
    assign LReady   = (state == WB_REQ) ? 1'b1 : !PWr;
    assign lHs      = LValid & LReady;
    assign pAcc     = PWr & !lHs;
    assign cntNext  = starveCnt + 1'b1;
    assign forceNow = (cntNext == LimitVal) || (starveCnt == LimitVal);

    // Arbiter FSM, starvation counter and registered write port.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= WB_NORM;
            starveCnt <= '0;
            StallPipe <= 1'b0;
            RW        <= '0;
            BusW      <= '0;
            RegWr     <= 1'b0;
        end else begin
            // Writes to $0 complete their handshake but never reach the register file.
            if (lHs) begin
                RegWr <= (LRW != '0);
                if (LRW != '0) begin
                    RW   <= LRW;
                    BusW <= LBus;
                end
            end else if (pAcc) begin
                RegWr <= (PRW != '0);
                if (PRW != '0) begin
                    RW   <= PRW;
                    BusW <= PBus;
                end
            end else begin
                RegWr <= 1'b0;
            end

            case (state)
                WB_NORM: begin
                    if (LValid && !LReady) begin
                        if (starveCnt != LimitVal) begin
                            starveCnt <= cntNext;
                        end
                        if (forceNow) begin
                            state     <= WB_REQ;
                            StallPipe <= 1'b1;
                        end
                    end else begin
                        starveCnt <= '0;
                    end
                end
                // LReady is high here, so REQ always resolves in one cycle: either the
                // handshake completes or L has withdrawn its request.
                WB_REQ: begin
                    state     <= WB_NORM;
                    StallPipe <= 1'b0;
                    starveCnt <= '0;
                end
                default: begin
                    state     <= WB_NORM;
                    StallPipe <= 1'b0;
                    starveCnt <= '0;
                end
            endcase
        end
    end

`ifdef WB_PROTO_CHECK_EN
    logic [NUM_REGS-1:0] busyVec;
    logic                protoHit;
`endif

    wb_scoreboard uScoreboard (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .SetEn (ResvEn),
        .SetRW (ResvRW),
        .ClrEn (lHs),
        .ClrRW (LRW),
        .QA    (QA),
        .QB    (QB),
        .HazA  (HazA),
        .HazB  (HazB)
`ifdef WB_PROTO_CHECK_EN
        ,
        .Busy  (busyVec)
`endif
    );

`ifdef WB_PROTO_CHECK_EN
    // Any protocol violation seen by the arbiter this cycle.
    always_comb begin
        protoHit = 1'b0;
        if (PWr && StallPipe) begin
            protoHit = 1'b1;
        end
        if (PWr && busyVec[PRW] && (PRW != '0)) begin
            protoHit = 1'b1;
        end
        if (ResvEn && busyVec[ResvRW]) begin
            protoHit = 1'b1;
        end
        if (lHs && !busyVec[LRW] && (LRW != '0)) begin
            protoHit = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ProtoErr <= 1'b0;
        end else if (protoHit) begin
            ProtoErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model. Define WB_PROTO_CHECK_EN to exercise ProtoErr.
module tb_regfile_wb_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        PWr;
    logic [4:0]  PRW;
    logic [31:0] PBus;
    logic        LValid;
    logic        LReady;
    logic [4:0]  LRW;
    logic [31:0] LBus;
    logic        ResvEn;
    logic [4:0]  ResvRW;
    logic [4:0]  QA;
    logic [4:0]  QB;
    logic        HazA;
    logic        HazB;
    logic        StallPipe;
    logic [4:0]  RW;
    logic [31:0] BusW;
    logic        RegWr;
`ifdef WB_PROTO_CHECK_EN
    logic        ProtoErr;
`endif

    always #5 Clk = ~Clk;

    regfile_wb_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .STARVE_W     (3)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .PWr       (PWr),
        .PRW       (PRW),
        .PBus      (PBus),
        .LValid    (LValid),
        .LReady    (LReady),
        .LRW       (LRW),
        .LBus      (LBus),
        .ResvEn    (ResvEn),
        .ResvRW    (ResvRW),
        .QA        (QA),
        .QB        (QB),
        .HazA      (HazA),
        .HazB      (HazB),
        .StallPipe (StallPipe),
        .RW        (RW),
        .BusW      (BusW),
        .RegWr     (RegWr)
`ifdef WB_PROTO_CHECK_EN
        ,
        .ProtoErr  (ProtoErr)
`endif
    );

    // Naive register file fed by the DUT; it does not protect $0 so stray writes show up.
    logic [31:0] rf [32];
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (RegWr) begin
            rf[RW] <= BusW;
        end
    end

    int errCount   = 0;
    int checkCount = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state.
    bit        mStall;
    int        mStreak;
    bit [31:0] mBusy;
    bit [4:0]  mRW;
    bit [31:0] mBus;
    bit        mRegWr;
    bit        mLastHs;

    task automatic modelReset();
        mStall  = 0;
        mStreak = 0;
        mBusy   = '0;
        mRW     = '0;
        mBus    = '0;
        mRegWr  = 0;
        mLastHs = 0;
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic modelStep();
        bit ready;
        bit hs;
        ready = mStall || !PWr;
        hs    = LValid && ready;
        mRegWr = 0;
        if (hs) begin
            if (LRW != 0) begin
                mRW = LRW; mBus = LBus; mRegWr = 1;
            end
        end else if (PWr) begin
            if (PRW != 0) begin
                mRW = PRW; mBus = PBus; mRegWr = 1;
            end
        end
        if (hs) mBusy[LRW] = 0;
        if (ResvEn && ResvRW != 0) mBusy[ResvRW] = 1;
        // Consecutive unserved L cycles; the LIMIT-th one earns a forced slot.
        if (mStall) begin
            mStall = 0; mStreak = 0;
        end else if (LValid && !ready) begin
            mStreak++;
            if (mStreak == LIMIT) mStall = 1;
        end else begin
            mStreak = 0;
        end
        mLastHs = hs;
    endtask

    // Compare all outputs to the model, then clock. Entered shortly after a posedge.
    task automatic runCycle(input string pfx);
        #2;
        checkEq({pfx, "_lready"}, LReady, mStall || !PWr);
        checkEq({pfx, "_haza"}, HazA, mBusy[QA]);
        checkEq({pfx, "_hazb"}, HazB, mBusy[QB]);
        checkEq({pfx, "_stall"}, StallPipe, mStall);
        checkEq({pfx, "_regwr"}, RegWr, mRegWr);
        checkEq({pfx, "_rw"}, RW, mRW);
        checkEq({pfx, "_busw"}, BusW, mBus);
        modelStep();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        PWr = 0; PRW = '0; PBus = '0;
        LValid = 0; LRW = '0; LBus = '0;
        ResvEn = 0; ResvRW = '0;
    endtask

    task automatic doReset();
        Rst_n = 0;
        modelReset();
        @(posedge Clk);
        #1;
        Rst_n = 1;
    endtask

    initial begin
        idle();
        QA = '0; QB = '0;
        doReset();

        // Reset state.
        #1;
        checkEq("rst_regwr", RegWr, 0);
        checkEq("rst_stall", StallPipe, 0);
        checkEq("rst_rw", RW, 0);
        checkEq("rst_lready", LReady, 1);

        // P-only write, then the register file sees it.
        PWr = 1; PRW = 5'd5; PBus = 32'hDEADBEEF;
        runCycle("ponly");
        idle();
        checkEq("ponly_rw", RW, 5);
        checkEq("ponly_busw", BusW, 32'hDEADBEEF);
        checkEq("ponly_regwr", RegWr, 1);
        runCycle("ponly2");
        checkEq("ponly_rf5", rf[5], 32'hDEADBEEF);

        // Contention: P every cycle, L waits LIMIT cycles, then gets a forced slot.
        ResvEn = 1; ResvRW = 5'd7; QA = 5'd7;
        runCycle("resv7");
        idle();
        for (int i = 0; i < LIMIT; i++) begin
            PWr = 1; PRW = 5'd3; PBus = 32'h1000 + i;
            LValid = 1; LRW = 5'd7; LBus = 32'h7;
            #1;
            checkEq("cont_lready_lo", LReady, 0);
            checkEq("cont_stall_lo", StallPipe, 0);
            runCycle("cont");
        end
        checkEq("cont_stall_hi", StallPipe, 1);
        PWr = 0;
        #1;
        checkEq("cont_lready_hi", LReady, 1);
        runCycle("cont_force");
        idle();
        checkEq("cont_regwr", RegWr, 1);
        checkEq("cont_rw", RW, 7);
        checkEq("cont_busw", BusW, 32'h7);
        checkEq("cont_stall_rel", StallPipe, 0);
        checkEq("cont_haza_clr", HazA, 0);

        // Scoreboard set, clear, and set-wins-over-clear on the same register.
        QA = 5'd9; QB = 5'd9;
        ResvEn = 1; ResvRW = 5'd9;
        runCycle("sb_set");
        idle();
        checkEq("sb_haza_set", HazA, 1);
        LValid = 1; LRW = 5'd9; LBus = 32'h99;
        runCycle("sb_clr");
        idle();
        checkEq("sb_haza_clr", HazA, 0);
        ResvEn = 1; ResvRW = 5'd9;
        runCycle("sb_set2");
        ResvEn = 1; ResvRW = 5'd9; LValid = 1; LRW = 5'd9; LBus = 32'h9A;
        runCycle("sb_both");
        idle();
        checkEq("sb_set_wins", HazB, 1);
        LValid = 1; LRW = 5'd9; LBus = 32'h9B;
        runCycle("sb_tidy");
        idle();

        // $0 destination: handshake completes, no write, scoreboard untouched.
        QA = 5'd0;
        LValid = 1; LRW = 5'd0; LBus = 32'h12345678;
        #1;
        checkEq("zero_lready", LReady, 1);
        runCycle("zero");
        idle();
        checkEq("zero_regwr", RegWr, 0);
        checkEq("zero_haza", HazA, 0);
        runCycle("zero2");
        checkEq("zero_rf0", rf[0], 0);

        // Reset in the middle of a forced slot.
        ResvEn = 1; ResvRW = 5'd11; QA = 5'd11;
        runCycle("mid_resv");
        idle();
        for (int i = 0; i < LIMIT; i++) begin
            PWr = 1; PRW = 5'd4; PBus = 32'h4444_0000 + i;
            LValid = 1; LRW = 5'd11; LBus = 32'hB;
            runCycle("mid_cont");
        end
        PWr = 0;
        checkEq("mid_stall_hi", StallPipe, 1);
        #1;
        Rst_n = 0;
        #1;
        checkEq("mid_rst_stall", StallPipe, 0);
        checkEq("mid_rst_regwr", RegWr, 0);
        checkEq("mid_rst_haza", HazA, 0);
        checkEq("mid_rst_lready1", LReady, 1);
        PWr = 1;
        #1;
        checkEq("mid_rst_lready0", LReady, 0);
        idle();
        modelReset();
        @(posedge Clk);
        #1;
        Rst_n = 1;
        // Counter restarted from zero: three waiting cycles must not force a slot.
        for (int i = 0; i < LIMIT - 1; i++) begin
            PWr = 1; PRW = 5'd2; PBus = 32'h2;
            LValid = 1; LRW = 5'd11; LBus = 32'hC;
            runCycle("post_rst");
        end
        idle();
        runCycle("post_idle");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if (!(LValid && !mLastHs && $urandom_range(0, 19) != 0)) begin
                LValid = ($urandom_range(0, 2) == 0);
                LRW    = 5'($urandom_range(0, 15));
                LBus   = $urandom();
            end
            PWr    = mStall ? 1'b0 : ($urandom_range(0, 3) != 0);
            PRW    = 5'($urandom_range(0, 15));
            PBus   = $urandom();
            ResvEn = ($urandom_range(0, 3) == 0);
            ResvRW = 5'($urandom_range(0, 15));
            QA     = 5'($urandom_range(0, 15));
            QB     = 5'($urandom_range(0, 15));
            runCycle("rnd");
        end
        idle();

`ifdef WB_PROTO_CHECK_EN
        // WAW on a reserved register latches ProtoErr until reset.
        doReset();
        #1;
        checkEq("pe_rst", ProtoErr, 0);
        QA = 5'd9;
        ResvEn = 1; ResvRW = 5'd9;
        runCycle("pe_resv");
        idle();
        checkEq("pe_quiet", ProtoErr, 0);
        PWr = 1; PRW = 5'd9; PBus = 32'h5;
        runCycle("pe_waw");
        idle();
        checkEq("pe_set", ProtoErr, 1);
        repeat (3) runCycle("pe_hold");
        checkEq("pe_sticky", ProtoErr, 1);
        Rst_n = 0;
        #1;
        checkEq("pe_clr", ProtoErr, 0);
        Rst_n = 1;
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
